// File: rtl/lisnoc_link_sink_measure.sv
// Receive-side sink for a lisnoc link: consumes flits per VC, checks packet
// framing and accumulates latency statistics from head-flit timestamps.
module lisnoc_link_sink_measure #(
    parameter int flit_width = 34,
    parameter int vchannels  = 1,
    parameter int ts_width   = 16,
    parameter int cnt_width  = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [flit_width-1:0]          flit,
    input  logic [vchannels-1:0]           valid,
    output logic [vchannels-1:0]           ready,
    input  logic [vchannels-1:0]           vc_enable,
    input  logic                           stall,
    input  logic                           clear,
    output logic [ts_width-1:0]            now,
    output logic [cnt_width-1:0]           flit_count,
    output logic [vchannels*cnt_width-1:0] pkt_count,
    output logic [cnt_width-1:0]           lat_sum,
    output logic [ts_width-1:0]            lat_max,
    output logic [vchannels-1:0]           err_framing,
    output logic                           err_multi
);
    typedef enum logic {IDLE, INPKT} state_t;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    state_t                state_q [vchannels];
    state_t                state_d [vchannels];
    logic [ts_width-1:0]   ts_q    [vchannels];
    logic [ts_width-1:0]   ts_d    [vchannels];
    logic [cnt_width-1:0]  pkt_q   [vchannels];

    logic [ts_width-1:0]   now_q;
    logic [cnt_width-1:0]  flit_q;
    logic [cnt_width-1:0]  lat_sum_q;
    logic [ts_width-1:0]   lat_max_q;
    logic [vchannels-1:0]  err_framing_q;
    logic                  err_multi_q;

    logic [1:0]            ftype;
    logic [ts_width-1:0]   payload_ts;
    logic                  unused_payload;
    logic                  multi;
    logic [vchannels-1:0]  acc;
    logic [vchannels-1:0]  comp_vec;
    logic [vchannels-1:0]  ferr;
    logic [ts_width-1:0]   comp_ts;
    logic [ts_width-1:0]   lat;
    logic [cnt_width:0]    sum_ext;
    logic [cnt_width-1:0]  sum_sat;

    assign ftype          = flit[flit_width-1 -: 2];
    assign payload_ts     = flit[ts_width-1:0];
    assign unused_payload = ^flit[flit_width-3:ts_width];

    // Clearing the lowest set bit leaves something only if two or more were set
    assign multi = |(valid & (valid - vchannels'(1)));
    assign ready = vc_enable & {vchannels{~stall & rst_n}};
    assign acc   = valid & ready & {vchannels{~multi}};

    always_comb begin
        comp_vec = '0;
        ferr     = '0;
        comp_ts  = '0;
        for (int v = 0; v < vchannels; v++) begin
            state_d[v] = state_q[v];
            ts_d[v]    = ts_q[v];
            if (acc[v]) begin
                case (state_q[v])
                    IDLE: begin
                        case (ftype)
                            T_HEAD: begin
                                state_d[v] = INPKT;
                                ts_d[v]    = payload_ts;
                            end
                            T_SINGLE: begin
                                comp_vec[v] = 1'b1;
                                comp_ts     = payload_ts;
                            end
                            default: ferr[v] = 1'b1;
                        endcase
                    end
                    INPKT: begin
                        case (ftype)
                            T_BODY: ;
                            T_TAIL: begin
                                comp_vec[v] = 1'b1;
                                comp_ts     = ts_q[v];
                                state_d[v]  = IDLE;
                            end
                            T_HEAD: begin
                                ferr[v] = 1'b1;
                                ts_d[v] = payload_ts;
                            end
                            default: begin
                                ferr[v]     = 1'b1;
                                comp_vec[v] = 1'b1;
                                comp_ts     = payload_ts;
                                state_d[v]  = IDLE;
                            end
                        endcase
                    end
                    default: state_d[v] = IDLE;
                endcase
            end
        end
    end

    // Modular difference absorbs timestamp wrap
    assign lat     = now_q - comp_ts;
    assign sum_ext = {1'b0, lat_sum_q} + (cnt_width+1)'(lat);
    assign sum_sat = sum_ext[cnt_width] ? '1 : sum_ext[cnt_width-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_q         <= '0;
            flit_q        <= '0;
            lat_sum_q     <= '0;
            lat_max_q     <= '0;
            err_framing_q <= '0;
            err_multi_q   <= 1'b0;
            for (int v = 0; v < vchannels; v++) begin
                state_q[v] <= IDLE;
                ts_q[v]    <= '0;
                pkt_q[v]   <= '0;
            end
        end else begin
            now_q <= now_q + ts_width'(1);
            for (int v = 0; v < vchannels; v++) begin
                state_q[v] <= state_d[v];
                ts_q[v]    <= ts_d[v];
            end
            if (clear) begin
                flit_q        <= '0;
                lat_sum_q     <= '0;
                lat_max_q     <= '0;
                err_framing_q <= '0;
                err_multi_q   <= 1'b0;
                for (int v = 0; v < vchannels; v++) pkt_q[v] <= '0;
            end else begin
                if (|acc) flit_q <= flit_q + cnt_width'(1);
                for (int v = 0; v < vchannels; v++)
                    if (comp_vec[v]) pkt_q[v] <= pkt_q[v] + cnt_width'(1);
                if (|comp_vec) begin
                    lat_sum_q <= sum_sat;
                    if (lat > lat_max_q) lat_max_q <= lat;
                end
                err_framing_q <= err_framing_q | ferr;
                if (multi) err_multi_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < vchannels; g++) begin : g_pkt
        assign pkt_count[g*cnt_width +: cnt_width] = pkt_q[g];
    end

    assign now         = now_q;
    assign flit_count  = flit_q;
    assign lat_sum     = lat_sum_q;
    assign lat_max     = lat_max_q;
    assign err_framing = err_framing_q;
    assign err_multi   = err_multi_q;
endmodule

// File: tb/tb_lisnoc_link_sink_measure.sv
// Bench for lisnoc_link_sink_measure: vector table through a scoreboard queue,
// plus hand sequences for mid-packet reset, timestamp wrap and saturation.
module tb_lisnoc_link_sink_measure;
    localparam int FW = 34;
    localparam int VC = 2;
    localparam int TS = 16;
    localparam int CW = 32;
    localparam int SCW = 8;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] T = 2'b10;
    localparam logic [1:0] S = 2'b11;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [FW-1:0]   flit = '0;
    logic [VC-1:0]   valid = '0;
    logic [VC-1:0]   vc_enable = 2'b11;
    logic            stall = 1'b0;
    logic            clear = 1'b0;
    logic [VC-1:0]   ready;
    logic [TS-1:0]   now;
    logic [CW-1:0]   flit_count;
    logic [VC*CW-1:0] pkt_count;
    logic [CW-1:0]   lat_sum;
    logic [TS-1:0]   lat_max;
    logic [VC-1:0]   err_framing;
    logic            err_multi;

    logic [VC-1:0]    s_ready;
    logic [TS-1:0]    s_now;
    logic [SCW-1:0]   s_flit_count;
    logic [VC*SCW-1:0] s_pkt_count;
    logic [SCW-1:0]   s_lat_sum;
    logic [TS-1:0]    s_lat_max;
    logic [VC-1:0]    s_err_framing;
    logic             s_err_multi;

    lisnoc_link_sink_measure #(
        .flit_width(FW), .vchannels(VC), .ts_width(TS), .cnt_width(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flit(flit), .valid(valid), .ready(ready),
        .vc_enable(vc_enable), .stall(stall), .clear(clear), .now(now),
        .flit_count(flit_count), .pkt_count(pkt_count), .lat_sum(lat_sum),
        .lat_max(lat_max), .err_framing(err_framing), .err_multi(err_multi)
    );

    // Narrow-counter copy makes lat_sum saturation reachable in a short run
    lisnoc_link_sink_measure #(
        .flit_width(FW), .vchannels(VC), .ts_width(TS), .cnt_width(SCW)
    ) sat_dut (
        .clk(clk), .rst_n(rst_n), .flit(flit), .valid(valid), .ready(s_ready),
        .vc_enable(vc_enable), .stall(stall), .clear(clear), .now(s_now),
        .flit_count(s_flit_count), .pkt_count(s_pkt_count),
        .lat_sum(s_lat_sum), .lat_max(s_lat_max),
        .err_framing(s_err_framing), .err_multi(s_err_multi)
    );

    always #5 clk = ~clk;

    logic [TS-1:0] tb_now;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_now <= '0;
        else        tb_now <= tb_now + 16'd1;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  en;
        logic        stall;
        logic        clr;
        logic [1:0]  ft;
        logic        absts;
        logic [15:0] ts;
        logic [1:0]  rdy;
        logic [31:0] fc;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] ls;
        logic [15:0] lm;
        logic [1:0]  ef;
        logic        em;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(
        logic [1:0] va, logic [1:0] en, logic st, logic cl, logic [1:0] ft,
        logic ab, logic [15:0] ts, logic [1:0] rdy, logic [31:0] fc,
        logic [31:0] p0, logic [31:0] p1, logic [31:0] ls, logic [15:0] lm,
        logic [1:0] ef, logic em);
        vec_t r;
        r.valid = va; r.en = en; r.stall = st; r.clr = cl; r.ft = ft;
        r.absts = ab; r.ts = ts; r.rdy = rdy; r.fc = fc; r.p0 = p0;
        r.p1 = p1; r.ls = ls; r.lm = lm; r.ef = ef; r.em = em;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        logic [15:0] tsv;
        @(negedge clk);
        tsv = v.absts ? v.ts : 16'(tb_now - v.ts);
        valid = v.valid;
        vc_enable = v.en;
        stall = v.stall;
        clear = v.clr;
        flit = {v.ft, 16'h0, tsv};
        exp_q.push_back(v);
        #1;
        chk("ready", 32'(ready), 32'(v.rdy));
        chk("now", 32'(now), 32'(tb_now));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("flit_count", flit_count, e.fc);
        chk("pkt_count0", pkt_count[0 +: CW], e.p0);
        chk("pkt_count1", pkt_count[CW +: CW], e.p1);
        chk("lat_sum", lat_sum, e.ls);
        chk("lat_max", 32'(lat_max), 32'(e.lm));
        chk("err_framing", 32'(err_framing), 32'(e.ef));
        chk("err_multi", 32'(err_multi), 32'(e.em));
        chk("sat_lat_sum", 32'(s_lat_sum), (e.ls > 32'd255) ? 32'd255 : e.ls);
    endtask

    initial begin
        // va en st cl ft ab ts | rdy fc p0 p1 ls lm ef em
        tbl.push_back(mk(2'b00,2'b11,0,0,B,0,0, 2'b11,0,0,0,0,0,0,0));
        tbl.push_back(mk(2'b10,2'b11,0,0,H,0,0, 2'b11,1,0,0,0,0,0,0));
        tbl.push_back(mk(2'b10,2'b11,0,0,B,0,0, 2'b11,2,0,0,0,0,0,0));
        tbl.push_back(mk(2'b10,2'b11,0,0,B,0,0, 2'b11,3,0,0,0,0,0,0));
        tbl.push_back(mk(2'b10,2'b11,0,0,T,0,0, 2'b11,4,0,1,3,3,0,0));
        tbl.push_back(mk(2'b00,2'b11,0,1,B,0,0, 2'b11,0,0,0,0,0,0,0));
        tbl.push_back(mk(2'b01,2'b11,0,0,S,0,5, 2'b11,1,1,0,5,5,0,0));
        tbl.push_back(mk(2'b00,2'b11,0,1,B,0,0, 2'b11,0,0,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(2'b01,2'b11,1,0,S,0,2, 2'b00,0,0,0,0,0,0,0));
        tbl.push_back(mk(2'b01,2'b11,0,0,S,0,2, 2'b11,1,1,0,2,2,0,0));
        tbl.push_back(mk(2'b00,2'b11,0,0,S,0,2, 2'b11,1,1,0,2,2,0,0));
        tbl.push_back(mk(2'b01,2'b10,0,0,S,0,2, 2'b10,1,1,0,2,2,0,0));
        tbl.push_back(mk(2'b00,2'b11,0,1,B,0,0, 2'b11,0,0,0,0,0,0,0));
        tbl.push_back(mk(2'b01,2'b11,0,0,T,0,0, 2'b11,1,0,0,0,0,2'b01,0));
        tbl.push_back(mk(2'b01,2'b11,0,0,H,0,1, 2'b11,2,0,0,0,0,2'b01,0));
        tbl.push_back(mk(2'b01,2'b11,0,0,H,0,4, 2'b11,3,0,0,0,0,2'b01,0));
        tbl.push_back(mk(2'b01,2'b11,0,0,T,0,0, 2'b11,4,1,0,5,5,2'b01,0));
        tbl.push_back(mk(2'b11,2'b11,0,0,S,0,0, 2'b11,4,1,0,5,5,2'b01,1));
        tbl.push_back(mk(2'b00,2'b11,0,1,B,0,0, 2'b11,0,0,0,0,0,0,0));
        tbl.push_back(mk(2'b01,2'b11,0,0,S,0,200, 2'b11,1,1,0,200,200,0,0));
        tbl.push_back(mk(2'b01,2'b11,0,0,S,0,200, 2'b11,2,2,0,400,200,0,0));
        tbl.push_back(mk(2'b01,2'b11,0,0,S,0,10, 2'b11,3,3,0,410,200,0,0));
        tbl.push_back(mk(2'b10,2'b11,0,0,H,0,0, 2'b11,4,3,0,410,200,0,0));

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_now", 32'(now), 32'd0);
        chk("reset_fc", flit_count, 32'd0);
        chk("reset_ls", lat_sum, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset with a packet open on VC1: everything must return to zero
        @(negedge clk);
        valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_fc", flit_count, 32'd0);
        chk("midrst_p0", pkt_count[0 +: CW], 32'd0);
        chk("midrst_ls", lat_sum, 32'd0);
        chk("midrst_lm", 32'(lat_max), 32'd0);
        chk("midrst_now", 32'(now), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Body right after reset proves VC1 is idle; then a wrapped timestamp
        step(mk(2'b10,2'b11,0,0,B,0,0, 2'b11,1,0,0,0,0,2'b10,0));
        step(mk(2'b10,2'b11,0,0,H,1,16'hFFFE, 2'b11,2,0,0,0,0,2'b10,0));
        step(mk(2'b10,2'b11,0,0,T,0,0, 2'b11,3,0,1,5,5,2'b10,0));

        @(negedge clk);
        valid = '0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
